// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a servo PWM line in clk_en
// ticks and maps it back to a servo direction (UP / DOWN / STAY).
// Nominal on-times and direction codes normally come from the motors header.
// The fallbacks below apply when that header has not been included.
// Optional feature macro: SERVO_PWM_DEC_FILTER_EN. When it is defined, a
// direction is only reported after two consecutive pulses decode to the same
// class.

`ifndef SERVO_PWM_BITS
`define SERVO_PWM_BITS 8
`endif
`ifndef SERVO_PWM_UP
`define SERVO_PWM_UP 200
`endif
`ifndef SERVO_PWM_DOWN
`define SERVO_PWM_DOWN 100
`endif
`ifndef SERVO_PWM_CENTER
`define SERVO_PWM_CENTER 150
`endif
`ifndef SERVO_DIR_STAY
`define SERVO_DIR_STAY 2'd0
`endif
`ifndef SERVO_DIR_UP
`define SERVO_DIR_UP 2'd1
`endif
`ifndef SERVO_DIR_DOWN
`define SERVO_DIR_DOWN 2'd2
`endif

module servo_pwm_decoder #(
  parameter int TOLERANCE     = 8,
  parameter int TIMEOUT_TICKS = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        pwm_in,
  output logic [`SERVO_PWM_BITS-1:0]  on_time,
  output logic [1:0]                  dir,
  output logic                        valid,
  output logic                        unknown,
  output logic                        timeout
);

  localparam int PW = `SERVO_PWM_BITS;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [PW-1:0] UP_NOM     = PW'(`SERVO_PWM_UP);
  localparam logic [PW-1:0] DOWN_NOM   = PW'(`SERVO_PWM_DOWN);
  localparam logic [PW-1:0] CENTER_NOM = PW'(`SERVO_PWM_CENTER);
  localparam logic [PW-1:0] CNT_MAX    = '1;

  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] T_MAX_M1 = TW'(TIMEOUT_TICKS - 1);

  localparam logic [1:0] DIR_STAY = `SERVO_DIR_STAY;
  localparam logic [1:0] DIR_UP   = `SERVO_DIR_UP;
  localparam logic [1:0] DIR_DOWN = `SERVO_DIR_DOWN;

  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  logic [1:0]    sync_q;
  logic          lvl;
  logic          prev;
  logic          rise;
  logic          fall;
  logic [1:0]    state;
  logic [PW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          match;
  logic [1:0]    cls;

`ifdef SERVO_PWM_DEC_FILTER_EN
  logic          hist_valid;
  logic [1:0]    hist_cls;
`endif

  // Distance check done one bit wider and signed so a short pulse never wraps
  // around into a false match with a large nominal value.
  function automatic logic near(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic signed [PW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= $signed((PW+1)'(TOLERANCE));
  endfunction

  assign lvl  = sync_q[1];
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  // Two-flop synchronizer for the asynchronous PWM line, runs every clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pwm_in};
  end

  // Classify the current count; UP is checked first, then DOWN, then CENTER.
  always_comb begin
    match = 1'b1;
    cls   = DIR_STAY;
    if (near(cnt, UP_NOM))          cls = DIR_UP;
    else if (near(cnt, DOWN_NOM))   cls = DIR_DOWN;
    else if (near(cnt, CENTER_NOM)) cls = DIR_STAY;
    else                            match = 1'b0;
  end

  // Edge tracking, pulse measurement FSM, timeout watchdog and output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 1'b0;
      state      <= SYNC;
      cnt        <= '0;
      tcnt       <= '0;
      on_time    <= '0;
      dir        <= DIR_STAY;
      valid      <= 1'b0;
      unknown    <= 1'b0;
      timeout    <= 1'b0;
`ifdef SERVO_PWM_DEC_FILTER_EN
      hist_valid <= 1'b0;
      hist_cls   <= DIR_STAY;
`endif
    end else begin
      valid   <= 1'b0;
      unknown <= 1'b0;
      if (clk_en) begin
        prev <= lvl;

        if (rise) begin
          tcnt <= '0;
        end else if (tcnt == T_MAX_M1) begin
          tcnt    <= T_MAX;
          timeout <= 1'b1;
          dir     <= DIR_STAY;
        end else if (tcnt != T_MAX) begin
          tcnt <= tcnt + 1'b1;
        end

        case (state)
          SYNC: begin
            if (!lvl) state <= LOW;
          end
          LOW: begin
            if (rise) begin
              cnt   <= {{(PW-1){1'b0}}, 1'b1};
              state <= HIGH;
            end
          end
          HIGH: begin
            if (lvl) begin
              if (cnt == CNT_MAX) begin
                state   <= SYNC;
                unknown <= 1'b1;
`ifdef SERVO_PWM_DEC_FILTER_EN
                hist_valid <= 1'b0;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (fall) begin
              state <= LOW;
              if (match) begin
`ifdef SERVO_PWM_DEC_FILTER_EN
                hist_valid <= 1'b1;
                hist_cls   <= cls;
                if (hist_valid && hist_cls == cls) begin
                  on_time <= cnt;
                  dir     <= cls;
                  valid   <= 1'b1;
                  timeout <= 1'b0;
                end
`else
                on_time <= cnt;
                dir     <= cls;
                valid   <= 1'b1;
                timeout <= 1'b0;
`endif
              end else begin
                unknown <= 1'b1;
`ifdef SERVO_PWM_DEC_FILTER_EN
                hist_valid <= 1'b0;
`endif
              end
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: directed self-checking bench for servo_pwm_decoder.
// Assumes the fallback nominal values (UP=200, DOWN=100, CENTER=150 ticks,
// 8-bit counts, STAY=0/UP=1/DOWN=2) and a shortened timeout of 300 ticks.
// clk_en pulses every second clk.

module tb_servo_pwm_decoder;

  localparam int UP_T     = 200;
  localparam int DOWN_T   = 100;
  localparam int CENTER_T = 150;
  localparam int TMO      = 300;
  localparam logic [1:0] D_STAY = 2'd0;
  localparam logic [1:0] D_UP   = 2'd1;
  localparam logic [1:0] D_DOWN = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] on_time;
  logic [1:0] dir;
  logic       valid;
  logic       unknown;
  logic       timeout;

  int total = 0;
  int bad = 0;
  int valid_seen = 0;
  int unk_seen = 0;
  int v0;
  int u0;

  servo_pwm_decoder #(.TOLERANCE(8), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .pwm_in(pwm_in),
    .on_time(on_time),
    .dir(dir),
    .valid(valid),
    .unknown(unknown),
    .timeout(timeout)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Tick enable: high for one full clk out of every two.
  initial begin
    forever begin
      @(negedge clk);
      clk_en = ~clk_en;
    end
  end

  // Count clk cycles with valid/unknown high, sampled away from the edge.
  always @(negedge clk) begin
    if (valid === 1'b1) valid_seen++;
    if (unknown === 1'b1) unk_seen++;
  end

  // Overall watchdog.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance n clk_en edges, then step 1 ns past the edge.
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (clk_en !== 1'b1);
    end
    #1;
  endtask

  // Send one high pulse of n ticks and allow time for the decode to land.
  task automatic send_pulse(input int n);
    tick_wait(1);
    pwm_in = 1'b1;
    tick_wait(n);
    pwm_in = 1'b0;
    tick_wait(6);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (on_time !== 8'd0) begin bad++; $display("[TB] FAIL reset_on_time: got %0d want 0", on_time); end
    total++;
    if (dir !== D_STAY) begin bad++; $display("[TB] FAIL reset_dir: got %0d want %0d", dir, D_STAY); end
    total++;
    if ({valid, unknown, timeout} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 000", {valid, unknown, timeout});
    end
    reset = 1'b0;
    tick_wait(4);
  endtask

`ifdef SERVO_PWM_DEC_FILTER_EN

  task automatic test_filter();
    v0 = valid_seen;
    send_pulse(UP_T);
    send_pulse(DOWN_T);
    total++;
    if (valid_seen !== v0) begin bad++; $display("[TB] FAIL filter_first: got %0d valid want 0", valid_seen - v0); end
    send_pulse(DOWN_T);
    total++;
    if (valid_seen !== v0 + 1) begin bad++; $display("[TB] FAIL filter_second: got %0d valid want 1", valid_seen - v0); end
    total++;
    if (dir !== D_DOWN) begin bad++; $display("[TB] FAIL filter_dir: got %0d want %0d", dir, D_DOWN); end
    total++;
    if (on_time !== 8'(DOWN_T)) begin bad++; $display("[TB] FAIL filter_on_time: got %0d want %0d", on_time, DOWN_T); end
    // An unknown pulse clears the history, so one more UP is not enough.
    v0 = valid_seen;
    u0 = unk_seen;
    send_pulse(UP_T + 9);
    send_pulse(UP_T);
    total++;
    if (unk_seen !== u0 + 1) begin bad++; $display("[TB] FAIL filter_unknown: got %0d want 1", unk_seen - u0); end
    total++;
    if (valid_seen !== v0) begin bad++; $display("[TB] FAIL filter_hist_clear: got %0d valid want 0", valid_seen - v0); end
    send_pulse(UP_T);
    total++;
    if (valid_seen !== v0 + 1 || dir !== D_UP) begin
      bad++; $display("[TB] FAIL filter_up_pair: got valid=%0d dir=%0d want valid=1 dir=%0d", valid_seen - v0, dir, D_UP);
    end
  endtask

`else

  task automatic test_nominal();
    int lens [3];
    logic [1:0] dirs [3];
    lens[0] = UP_T;     dirs[0] = D_UP;
    lens[1] = DOWN_T;   dirs[1] = D_DOWN;
    lens[2] = CENTER_T; dirs[2] = D_STAY;
    for (int k = 0; k < 3; k++) begin
      v0 = valid_seen;
      send_pulse(lens[k]);
      total++;
      if (valid_seen !== v0 + 1) begin bad++; $display("[TB] FAIL nominal_valid[%0d]: got %0d cycles want 1", k, valid_seen - v0); end
      total++;
      if (dir !== dirs[k]) begin bad++; $display("[TB] FAIL nominal_dir[%0d]: got %0d want %0d", k, dir, dirs[k]); end
      total++;
      if (on_time !== 8'(lens[k])) begin bad++; $display("[TB] FAIL nominal_on_time[%0d]: got %0d want %0d", k, on_time, lens[k]); end
    end
  endtask

  task automatic test_tolerance();
    v0 = valid_seen;
    send_pulse(UP_T + 8);
    total++;
    if (valid_seen !== v0 + 1 || dir !== D_UP || on_time !== 8'(UP_T + 8)) begin
      bad++; $display("[TB] FAIL tol_up_plus8: got valid=%0d dir=%0d on=%0d want 1/%0d/%0d", valid_seen - v0, dir, on_time, D_UP, UP_T + 8);
    end
    v0 = valid_seen;
    u0 = unk_seen;
    send_pulse(UP_T + 9);
    total++;
    if (unk_seen !== u0 + 1) begin bad++; $display("[TB] FAIL tol_up_plus9_unknown: got %0d want 1", unk_seen - u0); end
    total++;
    if (valid_seen !== v0) begin bad++; $display("[TB] FAIL tol_up_plus9_valid: got %0d want 0", valid_seen - v0); end
    total++;
    if (dir !== D_UP || on_time !== 8'(UP_T + 8)) begin
      bad++; $display("[TB] FAIL tol_hold: got dir=%0d on=%0d want %0d/%0d", dir, on_time, D_UP, UP_T + 8);
    end
    v0 = valid_seen;
    send_pulse(DOWN_T - 8);
    total++;
    if (valid_seen !== v0 + 1 || dir !== D_DOWN || on_time !== 8'(DOWN_T - 8)) begin
      bad++; $display("[TB] FAIL tol_down_minus8: got valid=%0d dir=%0d on=%0d want 1/%0d/%0d", valid_seen - v0, dir, on_time, D_DOWN, DOWN_T - 8);
    end
  endtask

  task automatic test_reset_mid_pulse();
    v0 = valid_seen;
    tick_wait(1);
    pwm_in = 1'b1;
    tick_wait(30);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (on_time !== 8'd0 || dir !== D_STAY) begin
      bad++; $display("[TB] FAIL midrst_values: got on=%0d dir=%0d want 0/%0d", on_time, dir, D_STAY);
    end
    reset = 1'b0;
    tick_wait(40);
    pwm_in = 1'b0;
    tick_wait(6);
    total++;
    if (valid_seen !== v0) begin bad++; $display("[TB] FAIL midrst_no_valid: got %0d want 0", valid_seen - v0); end
    send_pulse(CENTER_T);
    total++;
    if (valid_seen !== v0 + 1 || dir !== D_STAY || on_time !== 8'(CENTER_T)) begin
      bad++; $display("[TB] FAIL midrst_center: got valid=%0d dir=%0d on=%0d want 1/%0d/%0d", valid_seen - v0, dir, on_time, D_STAY, CENTER_T);
    end
  endtask

  task automatic test_overflow();
    v0 = valid_seen;
    u0 = unk_seen;
    send_pulse(256);
    total++;
    if (unk_seen !== u0 + 1) begin bad++; $display("[TB] FAIL ovf_unknown: got %0d want 1", unk_seen - u0); end
    total++;
    if (valid_seen !== v0 || on_time !== 8'(CENTER_T)) begin
      bad++; $display("[TB] FAIL ovf_hold: got valid=%0d on=%0d want 0/%0d", valid_seen - v0, on_time, CENTER_T);
    end
    send_pulse(DOWN_T);
    total++;
    if (valid_seen !== v0 + 1 || dir !== D_DOWN || on_time !== 8'(DOWN_T)) begin
      bad++; $display("[TB] FAIL ovf_then_down: got valid=%0d dir=%0d on=%0d want 1/%0d/%0d", valid_seen - v0, dir, on_time, D_DOWN, DOWN_T);
    end
  endtask

  task automatic test_timeout();
    send_pulse(UP_T);
    total++;
    if (dir !== D_UP || timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL tmo_start: got dir=%0d timeout=%b want %0d/0", dir, timeout, D_UP);
    end
    // Rise was seen 2 ticks after the drive; the limit is 302 ticks after it.
    tick_wait(80);
    total++;
    if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL tmo_early: got %b want 0", timeout); end
    tick_wait(30);
    total++;
    if (timeout !== 1'b1 || dir !== D_STAY) begin
      bad++; $display("[TB] FAIL tmo_set: got timeout=%b dir=%0d want 1/%0d", timeout, dir, D_STAY);
    end
    total++;
    if (on_time !== 8'(UP_T)) begin bad++; $display("[TB] FAIL tmo_on_time: got %0d want %0d", on_time, UP_T); end
    send_pulse(UP_T);
    total++;
    if (timeout !== 1'b0 || dir !== D_UP) begin
      bad++; $display("[TB] FAIL tmo_clear: got timeout=%b dir=%0d want 0/%0d", timeout, dir, D_UP);
    end
  endtask

`endif

  initial begin
    test_reset();
`ifdef SERVO_PWM_DEC_FILTER_EN
    test_filter();
`else
    test_nominal();
    test_tolerance();
    test_reset_mid_pulse();
    test_overflow();
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Measures the high time of an incoming servo PWM signal and converts it back to a servo direction (`ServoDir_t`).
- It is the inverse of the direction-to-on-time conversion in the motors block.
- Used for loopback self-test of the servo output path and for monitoring an external servo command line.
- Counts in the same `clk_en` tick base as the PWM generator, so measured `on_time` is directly comparable to `SERVO_PWM_UP`, `SERVO_PWM_DOWN` and `SERVO_PWM_CENTER` from the motors header.

Parameters:
- TOLERANCE, 8: maximum absolute tick difference between a measured on-time and a nominal value for a match.
- TIMEOUT_TICKS, 65535: `clk_en` ticks without a rising edge before `timeout` asserts (counter width `$clog2(TIMEOUT_TICKS+1)`).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  PWM tick enable, one-`clk` pulse per tick.
- pwm_in  in  1  asynchronous PWM input.
- on_time  out  `SERVO_PWM_BITS`  last accepted measured high time, in ticks.
- dir  out  `ServoDir_t`  decoded direction.
- valid  out  1  one-`clk` pulse when `on_time`/`dir` are updated.
- unknown  out  1  one-`clk` pulse when a completed pulse matched no nominal value.
- timeout  out  1  level: no rising edge seen within `TIMEOUT_TICKS`.

Behaviour:
- Reset values: `on_time`=0, `dir`=`SERVO_DIR_STAY`, `valid`=0, `unknown`=0, `timeout`=0, FSM=SYNC, counters=0.
- `pwm_in` passes through a 2-FF synchronizer clocked every `clk`, giving `lvl`. Reset clears both FFs to 0.
- Sampling is gated by `clk_en`. On each `clk_en` cycle, `prev` <= `lvl`. Rise = `lvl` & ~`prev`; fall = ~`lvl` & `prev`, both evaluated on `clk_en` cycles only.
- FSM states:
  - SYNC: wait for `lvl`=0 on a `clk_en` cycle, then go to LOW. A pulse already in progress at reset or after an error is discarded.
  - LOW: on rise, `cnt`<=1 and go to HIGH.
  - HIGH: on each `clk_en` with `lvl`=1, `cnt`<=`cnt`+1.
    - If `cnt` would exceed 2^`SERVO_PWM_BITS`-1: go to SYNC, no output update, `unknown` pulses.
    - On fall: classify `cnt` and go to LOW.
- Classification, done at the clock edge of the fall cycle:
  - |`cnt`-`SERVO_PWM_UP`| <= TOLERANCE → `SERVO_DIR_UP`.
  - else within TOLERANCE of `SERVO_PWM_DOWN` → `SERVO_DIR_DOWN`.
  - else within TOLERANCE of `SERVO_PWM_CENTER` → `SERVO_DIR_STAY`.
  - Check order is UP, DOWN, CENTER; the first match wins.
  - Compute differences at width `SERVO_PWM_BITS`+1, signed, with no wrap.
- On a match: `on_time`<=`cnt`, `dir`<=class, `valid`=1 for the following `clk` only.
- On no match: `on_time` and `dir` hold, `unknown`=1 for one `clk`.
- Latency: an edge on `pwm_in` reaches `lvl` after 2 `clk`. `valid` asserts in the `clk` after the `clk_en` cycle that detects the fall.
- Timeout:
  - `tcnt` increments on `clk_en` in every state and clears on rise.
  - When `tcnt` reaches TIMEOUT_TICKS: `timeout`<=1 and `dir`<=`SERVO_DIR_STAY`; `on_time` holds; `tcnt` saturates.
  - `timeout` clears on the next `valid`.
- Simultaneous events: a rise in the same `clk_en` cycle that `tcnt` reaches its limit counts as the rise, so no timeout.
- Reset mid-pulse: everything returns to reset values; the partial pulse is discarded via SYNC.
- `clk_en` held low: state frozen, apart from the synchronizer.

Optional Feature:
- Macro: `SERVO_PWM_DEC_FILTER_EN`.
- Defined: a matched class updates `dir`/`on_time`/`valid` only if the previous completed pulse produced the same class.
  - An unknown pulse or an overflow clears the history.
  - `timeout` still forces STAY immediately.
  - After reset, the first match is recorded only; `valid` first fires on the second consecutive match.
- Undefined: every matched pulse updates immediately, as described in Behaviour.

Test Plan:
- Reset, then pulses of exactly `SERVO_PWM_UP`, `SERVO_PWM_DOWN`, `SERVO_PWM_CENTER` ticks → `valid` pulses, `dir`=UP/DOWN/STAY, `on_time` equals the pulse length.
- Pulse of `SERVO_PWM_UP`+8 → UP. Pulse of `SERVO_PWM_UP`+9 (not within 8 of another nominal) → `unknown` pulse, `dir`/`on_time` unchanged.
- Assert `reset` while `pwm_in` is high mid-pulse, release while still high → no `valid` for that pulse; the next full CENTER pulse gives `valid`, `dir`=STAY.
- `pwm_in` held high for 2^`SERVO_PWM_BITS` ticks → `unknown` pulse, no `valid`; the following DOWN pulse decodes to DOWN.
- Send an UP pulse, then hold `pwm_in` low for TIMEOUT_TICKS ticks → `timeout`=1, `dir`=STAY. Next UP pulse → `timeout`=0, `dir`=UP.
- With `SERVO_PWM_DEC_FILTER_EN`: send UP, DOWN, DOWN → no `valid` on UP or on the first DOWN; `valid` with `dir`=DOWN on the second DOWN.
